audio_scheduler: RTL and testbench

// Time-shares the single audio tone path between background music and a collision sound effect (SFX).

---
 rtl/audio_pkg.sv | 19 +
 rtl/audio_scheduler_if.sv | 25 ++
 rtl/sfx_trig_queue.sv | 45 ++++
 rtl/audio_scheduler.sv | 126 ++++++++++++
 tb/tb_audio_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio scheduler: selector encoding, FSM states and index widths.
package audio_pkg;

  localparam int MUSIC_IDX_W = 12;
  localparam int SFX_IDX_W   = 5;
  localparam int PEND_W      = 3;

  localparam logic [1:0] SEL_SILENT = 2'b00;
  localparam logic [1:0] SEL_MUSIC  = 2'b01;
  localparam logic [1:0] SEL_SFX    = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUSIC = 2'd1,
    S_SFX   = 2'd2,
    S_GAP   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/audio_scheduler_if.sv
// Bundle between the game/collision logic and the audio scheduler, plus the tone-lookup side outputs.
interface audio_scheduler_if;
  import audio_pkg::*;

  logic                   beat_en;
  logic [2:0]             state;
  logic                   collision_trig;
  logic                   mute;
  logic [MUSIC_IDX_W-1:0] music_ibeat;
  logic [SFX_IDX_W-1:0]   sfx_ibeat;
  logic [1:0]             sel;
  logic                   sfx_busy;
  logic                   sfx_dropped;

  modport master (
    output beat_en, state, collision_trig, mute,
    input  music_ibeat, sfx_ibeat, sel, sfx_busy, sfx_dropped
  );

  modport slave (
    input  beat_en, state, collision_trig, mute,
    output music_ibeat, sfx_ibeat, sel, sfx_busy, sfx_dropped
  );

endinterface

// File: rtl/sfx_trig_queue.sv
// Collision edge detector with a saturating count of SFX requests waiting behind the current one.
module sfx_trig_queue
  import audio_pkg::*;
#(
  parameter int PENDING_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic collision_trig,
  input  logic accept_en,
  input  logic pop,
  output logic rise,
  output logic pending_nz,
  output logic dropped
);

  logic              trig_q;
  logic [PEND_W-1:0] pending;
  logic              full;

  assign rise       = collision_trig & ~trig_q;
  assign full       = (pending == PEND_W'(PENDING_MAX));
  assign pending_nz = (pending != '0);

  // A request arriving on the same edge as a pop simply takes the freed slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q  <= 1'b0;
      pending <= '0;
      dropped <= 1'b0;
    end else begin
      trig_q  <= collision_trig;
      dropped <= 1'b0;
      if (rise && accept_en) begin
        if (!pop) begin
          if (!full) pending <= pending + 3'd1;
          else       dropped <= 1'b1;
        end
      end else if (pop) begin
        pending <= pending - 3'd1;
      end
    end
  end

endmodule

// File: rtl/audio_scheduler.sv
// Time-shares the tone path between looping music and collision SFX; music freezes while SFX plays.
module audio_scheduler
  import audio_pkg::*;
#(
  parameter int         MUSIC_LEN        = 512,
  parameter int         SFX_LEN          = 16,
  parameter int         GAP_LEN          = 2,
  parameter int         PENDING_MAX      = 3,
  parameter logic [7:0] MUSIC_STATE_MASK = 8'b00000001
) (
  input  logic               clk,
  input  logic               rst,
  audio_scheduler_if.slave   bus
);

  localparam int GAP_W = $clog2(GAP_LEN + 1);

  sched_state_t           fsm, fsm_next;
  logic [2:0]             state_q;
  logic                   state_seen;
  logic                   state_chg;
  logic                   music_on;
  logic                   rise, pending_nz, dropped;
  logic                   accept_en, pop;
  logic                   sfx_last, gap_last;
  logic [MUSIC_IDX_W-1:0] music_q;
  logic [SFX_IDX_W-1:0]   sfx_q;
  logic [GAP_W-1:0]       gap_cnt;

  assign music_on  = MUSIC_STATE_MASK[bus.state];
  assign state_chg = state_seen && (bus.state != state_q);
  assign sfx_last  = bus.beat_en && (sfx_q == SFX_IDX_W'(SFX_LEN - 1));
  assign gap_last  = bus.beat_en && (gap_cnt == GAP_W'(GAP_LEN - 1));
  assign accept_en = (fsm == S_SFX) || (fsm == S_GAP);
  assign pop       = (fsm == S_GAP) && gap_last;

  assign bus.music_ibeat = music_q;
  assign bus.sfx_ibeat   = sfx_q;
  assign bus.sfx_dropped = dropped;

  sfx_trig_queue #(.PENDING_MAX(PENDING_MAX)) u_queue (
    .clk            (clk),
    .rst            (rst),
    .collision_trig (bus.collision_trig),
    .accept_en      (accept_en),
    .pop            (pop),
    .rise           (rise),
    .pending_nz     (pending_nz),
    .dropped        (dropped)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= S_IDLE;
    else     fsm <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      S_IDLE:  if (rise) fsm_next = S_SFX;
               else if (music_on) fsm_next = S_MUSIC;
      S_MUSIC: if (rise) fsm_next = S_SFX;
               else if (!music_on) fsm_next = S_IDLE;
      // The return target is decided only here, so a game-state change mid-SFX takes effect now.
      S_SFX:   if (sfx_last) begin
                 if (pending_nz || rise) fsm_next = S_GAP;
                 else if (music_on)      fsm_next = S_MUSIC;
                 else                    fsm_next = S_IDLE;
               end
      S_GAP:   if (gap_last) fsm_next = S_SFX;
      default: fsm_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.sel      = SEL_SILENT;
    bus.sfx_busy = 1'b0;
    case (fsm)
      S_MUSIC: bus.sel = SEL_MUSIC;
      S_SFX:   begin bus.sel = SEL_SFX; bus.sfx_busy = 1'b1; end
      S_GAP:   bus.sfx_busy = 1'b1;
      default: bus.sel = SEL_SILENT;
    endcase
    if (bus.mute) bus.sel = SEL_SILENT;
  end

  // state_seen keeps the first post-reset sample from looking like a game-state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= 3'd0;
      state_seen <= 1'b0;
    end else begin
      state_q    <= bus.state;
      state_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      music_q <= '0;
    end else if (state_chg) begin
      music_q <= '0;
    end else if (fsm == S_MUSIC && fsm_next == S_MUSIC && bus.beat_en) begin
      music_q <= (music_q == MUSIC_IDX_W'(MUSIC_LEN - 1)) ? '0 : music_q + 12'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sfx_q   <= '0;
      gap_cnt <= '0;
    end else begin
      if (fsm == S_SFX && fsm_next == S_SFX) begin
        if (bus.beat_en) sfx_q <= sfx_q + 5'd1;
      end else begin
        sfx_q <= '0;
      end
      if (fsm == S_GAP && fsm_next == S_GAP) begin
        if (bus.beat_en) gap_cnt <= gap_cnt + GAP_W'(1);
      end else begin
        gap_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_audio_scheduler.sv
// Directed-vector bench for audio_scheduler with short music loop (8 beats) and 16-beat SFX.
module tb_audio_scheduler;
  import audio_pkg::*;

  logic clk;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  audio_scheduler_if bus();

  audio_scheduler #(
    .MUSIC_LEN        (8),
    .SFX_LEN          (16),
    .GAP_LEN          (2),
    .PENDING_MAX      (3),
    .MUSIC_STATE_MASK (8'b00000001)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat();
    bus.beat_en = 1'b1;
    tick();
    bus.beat_en = 1'b0;
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) beat();
  endtask

  task automatic pulse_trig();
    bus.collision_trig = 1'b1;
    tick();
    bus.collision_trig = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.music_ibeat, bus.sfx_ibeat, bus.sel, bus.sfx_busy, bus.sfx_dropped} !== '0) begin
      n_miss++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {bus.music_ibeat, bus.sfx_ibeat, bus.sel, bus.sfx_busy, bus.sfx_dropped});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_vec++;
    if (bus.sel !== SEL_MUSIC || bus.music_ibeat !== 12'd0) begin
      n_miss++;
      $display("[TB] FAIL reset_to_music: got sel=%b music=%0d expected sel=01 music=0",
               bus.sel, bus.music_ibeat);
    end
  endtask

  task automatic test_music_loop();
    for (int i = 0; i < 10; i++) begin
      beat();
      n_vec++;
      if (bus.music_ibeat !== 12'((i + 1) % 8) || bus.sel !== SEL_MUSIC) begin
        n_miss++;
        $display("[TB] FAIL music_loop[%0d]: got music=%0d sel=%b expected music=%0d sel=01",
                 i, bus.music_ibeat, bus.sel, (i + 1) % 8);
      end
    end
  endtask

  task automatic test_preempt();
    beats(3);
    n_vec++;
    if (bus.music_ibeat !== 12'd5) begin
      n_miss++;
      $display("[TB] FAIL preempt_setup: got music=%0d expected 5", bus.music_ibeat);
    end
    // Beat and rise together: the rise must win and the music index must not move.
    bus.beat_en        = 1'b1;
    bus.collision_trig = 1'b1;
    tick();
    bus.beat_en        = 1'b0;
    bus.collision_trig = 1'b0;
    n_vec++;
    if (bus.sel !== SEL_SFX || bus.music_ibeat !== 12'd5 || bus.sfx_ibeat !== 5'd0 || bus.sfx_busy !== 1'b1) begin
      n_miss++;
      $display("[TB] FAIL preempt_enter: got sel=%b music=%0d sfx=%0d busy=%b expected 10/5/0/1",
               bus.sel, bus.music_ibeat, bus.sfx_ibeat, bus.sfx_busy);
    end
    beats(15);
    n_vec++;
    if (bus.sfx_ibeat !== 5'd15 || bus.sel !== SEL_SFX) begin
      n_miss++;
      $display("[TB] FAIL preempt_last_beat: got sfx=%0d sel=%b expected 15/10", bus.sfx_ibeat, bus.sel);
    end
    beat();
    n_vec++;
    if (bus.sel !== SEL_MUSIC || bus.music_ibeat !== 12'd5 || bus.sfx_ibeat !== 5'd0) begin
      n_miss++;
      $display("[TB] FAIL preempt_resume: got sel=%b music=%0d sfx=%0d expected 01/5/0",
               bus.sel, bus.music_ibeat, bus.sfx_ibeat);
    end
    beat();
    n_vec++;
    if (bus.music_ibeat !== 12'd6) begin
      n_miss++;
      $display("[TB] FAIL preempt_advance: got music=%0d expected 6", bus.music_ibeat);
    end
  endtask

  task automatic test_queue();
    int drops;
    drops = 0;
    pulse_trig();
    tick();
    n_vec++;
    if (bus.sel !== SEL_SFX) begin
      n_miss++;
      $display("[TB] FAIL queue_enter: got sel=%b expected 10", bus.sel);
    end
    for (int r = 0; r < 5; r++) begin
      bus.collision_trig = 1'b1;
      tick();
      if (bus.sfx_dropped === 1'b1) drops++;
      n_vec++;
      if (bus.sfx_dropped !== (r >= 3)) begin
        n_miss++;
        $display("[TB] FAIL queue_drop[%0d]: got %b expected %b", r, bus.sfx_dropped, r >= 3);
      end
      bus.collision_trig = 1'b0;
      tick();
      if (bus.sfx_dropped === 1'b1) drops++;
    end
    n_vec++;
    if (drops != 2) begin
      n_miss++;
      $display("[TB] FAIL queue_drop_count: got %0d expected 2", drops);
    end
    for (int k = 0; k < 4; k++) begin
      beats(16);
      if (k < 3) begin
        n_vec++;
        if (bus.sel !== SEL_SILENT || bus.sfx_busy !== 1'b1) begin
          n_miss++;
          $display("[TB] FAIL queue_gap[%0d]: got sel=%b busy=%b expected 00/1", k, bus.sel, bus.sfx_busy);
        end
        beat();
        n_vec++;
        if (bus.sel !== SEL_SILENT || bus.sfx_busy !== 1'b1) begin
          n_miss++;
          $display("[TB] FAIL queue_gap_hold[%0d]: got sel=%b busy=%b expected 00/1", k, bus.sel, bus.sfx_busy);
        end
        beat();
        n_vec++;
        if (bus.sel !== SEL_SFX || bus.sfx_ibeat !== 5'd0) begin
          n_miss++;
          $display("[TB] FAIL queue_next_sfx[%0d]: got sel=%b sfx=%0d expected 10/0", k, bus.sel, bus.sfx_ibeat);
        end
      end else begin
        n_vec++;
        if (bus.sel !== SEL_MUSIC || bus.sfx_busy !== 1'b0 || bus.music_ibeat !== 12'd6) begin
          n_miss++;
          $display("[TB] FAIL queue_done: got sel=%b busy=%b music=%0d expected 01/0/6",
                   bus.sel, bus.sfx_busy, bus.music_ibeat);
        end
      end
    end
  endtask

  task automatic test_state_change();
    pulse_trig();
    beats(3);
    bus.state = 3'd2;
    tick();
    n_vec++;
    if (bus.music_ibeat !== 12'd0 || bus.sel !== SEL_SFX || bus.sfx_ibeat !== 5'd3) begin
      n_miss++;
      $display("[TB] FAIL state_chg_mid_sfx: got music=%0d sel=%b sfx=%0d expected 0/10/3",
               bus.music_ibeat, bus.sel, bus.sfx_ibeat);
    end
    beats(13);
    n_vec++;
    if (bus.sel !== SEL_SILENT || bus.sfx_busy !== 1'b0 || bus.music_ibeat !== 12'd0) begin
      n_miss++;
      $display("[TB] FAIL state_chg_idle: got sel=%b busy=%b music=%0d expected 00/0/0",
               bus.sel, bus.sfx_busy, bus.music_ibeat);
    end
    bus.state = 3'd0;
    tick();
    n_vec++;
    if (bus.sel !== SEL_MUSIC || bus.music_ibeat !== 12'd0) begin
      n_miss++;
      $display("[TB] FAIL state_chg_back: got sel=%b music=%0d expected 01/0", bus.sel, bus.music_ibeat);
    end
  endtask

  task automatic test_held_trig();
    int  entries;
    int  drops;
    logic prev_busy;
    entries   = 0;
    drops     = 0;
    prev_busy = bus.sfx_busy;
    for (int i = 0; i < 100; i++) begin
      bus.beat_en        = (i % 4 == 3);
      bus.collision_trig = 1'b1;
      tick();
      if (bus.sfx_busy === 1'b1 && prev_busy !== 1'b1) entries++;
      if (bus.sfx_dropped === 1'b1) drops++;
      prev_busy = bus.sfx_busy;
    end
    bus.beat_en        = 1'b0;
    bus.collision_trig = 1'b0;
    tick();
    n_vec++;
    if (entries != 1 || drops != 0) begin
      n_miss++;
      $display("[TB] FAIL held_trig_count: got entries=%0d drops=%0d expected 1/0", entries, drops);
    end
    n_vec++;
    if (bus.sel !== SEL_MUSIC || bus.music_ibeat !== 12'd1) begin
      n_miss++;
      $display("[TB] FAIL held_trig_end: got sel=%b music=%0d expected 01/1", bus.sel, bus.music_ibeat);
    end
  endtask

  task automatic test_mute();
    pulse_trig();
    bus.mute = 1'b1;
    #1;
    n_vec++;
    if (bus.sel !== SEL_SILENT) begin
      n_miss++;
      $display("[TB] FAIL mute_immediate: got sel=%b expected 00", bus.sel);
    end
    beats(3);
    n_vec++;
    if (bus.sel !== SEL_SILENT || bus.sfx_ibeat !== 5'd3 || bus.sfx_busy !== 1'b1) begin
      n_miss++;
      $display("[TB] FAIL mute_counting: got sel=%b sfx=%0d busy=%b expected 00/3/1",
               bus.sel, bus.sfx_ibeat, bus.sfx_busy);
    end
    bus.mute = 1'b0;
    #1;
    n_vec++;
    if (bus.sel !== SEL_SFX) begin
      n_miss++;
      $display("[TB] FAIL mute_release: got sel=%b expected 10", bus.sel);
    end
    beats(13);
    n_vec++;
    if (bus.sel !== SEL_MUSIC || bus.music_ibeat !== 12'd1) begin
      n_miss++;
      $display("[TB] FAIL mute_sfx_end: got sel=%b music=%0d expected 01/1", bus.sel, bus.music_ibeat);
    end
  endtask

  task automatic test_reset_mid_sfx();
    beats(2);
    pulse_trig();
    beats(7);
    n_vec++;
    if (bus.sfx_ibeat !== 5'd7 || bus.music_ibeat !== 12'd3) begin
      n_miss++;
      $display("[TB] FAIL rst_mid_setup: got sfx=%0d music=%0d expected 7/3", bus.sfx_ibeat, bus.music_ibeat);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.music_ibeat, bus.sfx_ibeat, bus.sel, bus.sfx_busy, bus.sfx_dropped} !== '0) begin
      n_miss++;
      $display("[TB] FAIL rst_mid_async: got %h expected 0",
               {bus.music_ibeat, bus.sfx_ibeat, bus.sel, bus.sfx_busy, bus.sfx_dropped});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.sel !== SEL_SILENT || bus.sfx_busy !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL rst_mid_idle: got sel=%b busy=%b expected 00/0", bus.sel, bus.sfx_busy);
    end
    tick();
    n_vec++;
    if (bus.sel !== SEL_MUSIC || bus.music_ibeat !== 12'd0 || bus.sfx_ibeat !== 5'd0) begin
      n_miss++;
      $display("[TB] FAIL rst_mid_restart: got sel=%b music=%0d sfx=%0d expected 01/0/0",
               bus.sel, bus.music_ibeat, bus.sfx_ibeat);
    end
  endtask

  initial begin
    rst                = 1'b1;
    bus.beat_en        = 1'b0;
    bus.state          = 3'd0;
    bus.collision_trig = 1'b0;
    bus.mute           = 1'b0;
    $display("[TB] audio_scheduler directed run starting");
    test_reset();
    test_music_loop();
    test_preempt();
    test_queue();
    test_state_change();
    test_held_trig();
    test_mute();
    test_reset_mid_sfx();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
